serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Multi-cycle, digit-serial unsigned subtractor: diff = a_in - b_in - b_in_borrow (mod 2^WIDTH), with a borrow-out.
- Inverse companion to the team's ripple-carry generic adder. Processes DIGIT bits per clock through a registered borrow, so a wide operand uses a short DIGIT-bit subtract path.
- Valid/ready handshake on both the operand and result sides; sits in datapaths where the area of a full-width subtract is not acceptable.

Parameters:
- WIDTH, 24, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. WIDTH must be a multiple of DIGIT; N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block accepts operands this cycle.
- a_in  input  WIDTH  minuend.
- b_in  input  WIDTH  subtrahend.
- b_in_borrow  input  1  borrow-in (subtracted at bit 0).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference.
- borrow  output  1  borrow-out; 1 iff a_in < b_in + b_in_borrow (unsigned).
- ovf  output  1  signed overflow; present only with SERSUB_OVF_EN.

Behaviour:
- Single clock domain, clk. rst is synchronous and active-high.
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, out_valid=0, diff=0, borrow=0, ovf=0, internal shift registers, digit counter and borrow register all 0.
- in_ready = (state==IDLE) && !rst (combinational). It is 0 in BUSY and DONE.
- IDLE:
  - On in_valid && in_ready, latch a_in, b_in and b_in_borrow.
  - Borrow register takes b_in_borrow; counter=0; go to BUSY.
  - If in_valid is low, stay in IDLE.
- BUSY, each cycle:
  - Take the low DIGIT bits of the a and b shift registers and compute {bout, d} = a_lo - b_lo - brw.
  - Shift d into the top of the result shift register; shift a and b right by DIGIT.
  - brw <= bout; counter increments.
  - On the cycle counter==N-1, go to DONE.
  - Register diff <= final result and borrow <= final bout.
- DONE:
  - out_valid=1; diff, borrow and ovf stable.
  - On out_ready, go to IDLE; out_valid=0 from the next cycle.
  - diff, borrow and ovf keep their last values after leaving DONE, until the next completion.
- Latency: operand accepted at edge E; out_valid is high in the cycle after edge E+N (N BUSY cycles). Throughput is one operation per N+2 cycles at best.
- Holding out_ready high before DONE is legal; the result handshake then completes in the first DONE cycle.
- No new operand is accepted in the same cycle as the result handshake.
- in_valid while not in IDLE is ignored. Operands are not sampled, and no queueing occurs.
- Operand inputs may change freely after acceptance; the block uses only the latched copies.
- Wrap-around: the result is modulo 2^WIDTH. A full underflow, e.g. 0-1, gives all ones with borrow=1.
- b_in_borrow=1 with a_in==b_in gives diff = all ones, borrow=1.
- Reset in any state, including mid-BUSY: the operation is aborted and every register returns to its reset value on that edge. No partial result is ever presented.

Optional Feature:
- Macro: SERSUB_OVF_EN.
- Defined:
  - ovf output port exists.
  - In the same edge as the final digit, ovf <= (a_msb != b_msb) && (diff_msb != a_msb), using the latched operands' sign bits.
  - ovf resets to 0 and is held like diff.
- Undefined: no ovf port and no overflow logic. All other behaviour is identical.

Test Plan (WIDTH=24, DIGIT=4, N=6):
- Accept a=0x000010, b=0x000001, bin=0 -> out_valid high in the cycle after the 6th edge following acceptance; diff=0x00000F, borrow=0.
- a=0x000000, b=0x000001, bin=0 -> diff=0xFFFFFF, borrow=1. Then a=0xABCDEF, b=0x000000 -> diff=0xABCDEF, borrow=0.
- Borrow-in chaining across all digits:
  - a=0x123456, b=0x123455, bin=1 -> diff=0x000000, borrow=0.
  - a=0x123456, b=0x123456, bin=1 -> diff=0xFFFFFF, borrow=1.
- Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 with new operands -> in_ready=0, out_valid=1, diff/borrow unchanged, new operands ignored. After out_ready=1, IDLE is reached and in_ready=1 next cycle.
- Reset mid-operation: assert rst for 1 cycle on the 3rd BUSY cycle -> next cycle IDLE, out_valid=0, diff=0, borrow=0. The following op a=0x000100, b=0x000001 returns 0x0000FF.
- With SERSUB_OVF_EN defined:
  - a=0x800000, b=0x000001, bin=0 -> diff=0x7FFFFF, ovf=1, borrow=0.
  - a=0x7FFFFF, b=0x000001 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// The ovf signal exists only when SERSUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 24
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             b_in_borrow;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERSUB_OVF_EN
  logic             ovf;
`endif

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output in_valid, a_in, b_in, b_in_borrow, out_ready,
`ifdef SERSUB_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, diff, borrow
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a_in, b_in, b_in_borrow, out_ready,
`ifdef SERSUB_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, diff, borrow
  );

endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - bin (mod 2^WIDTH), with borrow-out.
// DIGIT bits are subtracted per cycle through a registered borrow; N = WIDTH/DIGIT cycles.
// Optional signed-overflow output is enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             brw_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             out_valid_q;
`ifdef SERSUB_OVF_EN
  logic             a_msb_q, b_msb_q, ovf_q;
`endif

  logic [DIGIT:0]   dsub;
  logic [DIGIT-1:0] dig;
  logic             bout;
  logic [WIDTH-1:0] res_nxt;

  // One digit of subtraction plus the result register after this digit is shifted in.
  always_comb begin
    dsub    = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw_q};
    dig     = dsub[DIGIT-1:0];
    bout    = dsub[DIGIT];
    res_nxt = (res_q >> DIGIT) | (WIDTH'(dig) << (WIDTH - DIGIT));
  end

  // Operand acceptance is blocked during reset so nothing is lost on the reset edge.
  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
`ifdef SERSUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

  // Control FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            a_q     <= bus.a_in;
            b_q     <= bus.b_in;
            brw_q   <= bus.b_in_borrow;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef SERSUB_OVF_EN
            a_msb_q <= bus.a_in[WIDTH-1];
            b_msb_q <= bus.b_in[WIDTH-1];
`endif
            state_q <= StBusy;
          end
        end
        StBusy: begin
          a_q   <= a_q >> DIGIT;
          b_q   <= b_q >> DIGIT;
          res_q <= res_nxt;
          brw_q <= bout;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            diff_q      <= res_nxt;
            borrow_q    <= bout;
            out_valid_q <= 1'b1;
`ifdef SERSUB_OVF_EN
            // Sign bits come from the latched operands; the shift registers have moved on.
            ovf_q       <= (a_msb_q != b_msb_q) && (dig[DIGIT-1] != a_msb_q);
`endif
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomised self-checking bench for serial_subtractor (WIDTH=24, DIGIT=4).
module tb_serial_subtractor;

  localparam int unsigned Width = 24;
  localparam int unsigned Digit = 4;
  localparam int unsigned N     = Width / Digit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(Width)) bus ();

  serial_subtractor #(
    .WIDTH(Width),
    .DIGIT(Digit)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operand values.
  task automatic model(input logic [23:0] a, input logic [23:0] b, input logic bin,
                       output logic [23:0] d, output logic bo, output logic ov);
    longint r, sa, sb, sr;
    r  = longint'(a) - longint'(b) - longint'(bin);
    bo = (r < 0);
    r  = r + 64'sd16777216 * 2;
    d  = r[23:0];
    sa = longint'(a) - (a[23] ? 64'sd16777216 : 64'sd0);
    sb = longint'(b) - (b[23] ? 64'sd16777216 : 64'sd0);
    sr = sa - sb - longint'(bin);
    ov = (sr > 64'sd8388607) || (sr < -64'sd8388608);
  endtask

  // Runs one operation; hold = DONE cycles with out_ready low (and junk offered on the input),
  // early = raise out_ready straight after acceptance.
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic bin,
                       input int hold, input bit early);
    logic [23:0] ed;
    logic        eb, eo;
    int          cyc;
    model(a, b, bin, ed, eb, eo);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid    = 1'b1;
    bus.a_in        = a;
    bus.b_in        = b;
    bus.b_in_borrow = bin;
    tick();
    bus.in_valid    = 1'b0;
    bus.a_in        = 24'($urandom);
    bus.b_in        = 24'($urandom);
    bus.b_in_borrow = 1'($urandom);
    if (early) bus.out_ready = 1'b1;
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check_eq("latency", cyc, N);
    check_eq("diff", {8'd0, bus.diff}, {8'd0, ed});
    check_eq("borrow", {31'd0, bus.borrow}, {31'd0, eb});
`ifdef SERSUB_OVF_EN
    check_eq("ovf", {31'd0, bus.ovf}, {31'd0, eo});
`endif
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.a_in     = 24'($urandom);
        bus.b_in     = 24'($urandom);
        tick();
        check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_eq("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("bp_diff", {8'd0, bus.diff}, {8'd0, ed});
        check_eq("bp_borrow", {31'd0, bus.borrow}, {31'd0, eb});
      end
      bus.out_ready = 1'b1;
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("out_valid_drop", {31'd0, bus.out_valid}, 32'd0);
    check_eq("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    check_eq("diff_held", {8'd0, bus.diff}, {8'd0, ed});
    check_eq("borrow_held", {31'd0, bus.borrow}, {31'd0, eb});
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.a_in        = '0;
    bus.b_in        = '0;
    bus.b_in_borrow = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_diff", {8'd0, bus.diff}, 32'd0);
    check_eq("rst_borrow", {31'd0, bus.borrow}, 32'd0);
`ifdef SERSUB_OVF_EN
    check_eq("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Directed cases.
    do_op(24'h000010, 24'h000001, 1'b0, 0, 1'b0);
    do_op(24'h000000, 24'h000001, 1'b0, 0, 1'b0);
    do_op(24'hABCDEF, 24'h000000, 1'b0, 0, 1'b0);
    do_op(24'h123456, 24'h123455, 1'b1, 0, 1'b0);
    do_op(24'h123456, 24'h123456, 1'b1, 0, 1'b1);
    do_op(24'h800000, 24'h000001, 1'b0, 0, 1'b0);
    do_op(24'h7FFFFF, 24'h000001, 1'b0, 0, 1'b0);
    do_op(24'h7FFFFF, 24'hFFFFFF, 1'b0, 0, 1'b0);
    do_op(24'h5A5A5A, 24'hA5A5A5, 1'b1, 5, 1'b0);

    // Reset on the third BUSY cycle aborts the operation.
    bus.in_valid = 1'b1;
    bus.a_in     = 24'h00F000;
    bus.b_in     = 24'h000001;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("abort_diff", {8'd0, bus.diff}, 32'd0);
    check_eq("abort_borrow", {31'd0, bus.borrow}, 32'd0);
    check_eq("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check_eq("abort_no_result", {31'd0, bus.out_valid}, 32'd0);
    end
    do_op(24'h000100, 24'h000001, 1'b0, 0, 1'b0);

    // Random operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      do_op(24'($urandom), 24'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
